// File: rtl/ae_pkg.sv
// ae_pkg: shared definitions for the ae_pipe logic lane.
//   - Truth-table function codes. Bit {a,b} of a code is the result for that
//     operand-bit pair, so code[0] covers a=0,b=0 and code[3] covers a=1,b=1.
//   - ae_bit(): evaluates one code for a single operand-bit pair.
package ae_pkg;

    localparam logic [3:0] AE_F_ZERO  = 4'b0000;
    localparam logic [3:0] AE_F_NOR   = 4'b0001;
    localparam logic [3:0] AE_F_NOTA  = 4'b0011;
    localparam logic [3:0] AE_F_XOR   = 4'b0110;
    localparam logic [3:0] AE_F_AND   = 4'b1000;
    localparam logic [3:0] AE_F_PASSB = 4'b1010;
    localparam logic [3:0] AE_F_OR    = 4'b1110;
    localparam logic [3:0] AE_F_ONES  = 4'b1111;

    // The operand bits form the index into the 4-entry truth table.
    function automatic logic ae_bit(input logic [3:0] f, input logic a, input logic b);
        return f[{a, b}];
    endfunction

endpackage

// File: rtl/ae_flags.sv
// ae_flags: purely combinational result flags for a WIDTH-bit vector.
// Ports:
//   vec   in  WIDTH  vector to classify
//   zero  out 1      vec == 0
//   ones  out 1      vec == all ones
//   par   out 1      XOR of all bits of vec
//   pop   out PW     number of 1 bits in vec
module ae_flags #(
    parameter int WIDTH = 32,
    parameter int PW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic             zero,
    output logic             ones,
    output logic             par,
    output logic [PW-1:0]    pop
);

    assign zero = ~|vec;
    assign ones = &vec;
    assign par  = ^vec;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PW'(vec[i]);
        end
    end

endmodule

// File: rtl/ae_pipe.sv
// ae_pipe: two-stage pipelined bitwise logic unit with valid/ready handshake.
// Applies any of the 16 two-input Boolean functions (truth-table code in_f)
// across a WIDTH-bit operand pair. Operand A can come from an accumulator that
// captures every accepted result, so chained operations run back to back.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake
//   in_f                 truth-table function code
//   in_acc               1 = accumulator replaces in_a as operand A
//   in_a, in_b           operands
//   out_valid/out_ready  output handshake
//   out_y                result
//   out_zero/ones/par    result flags (== 0, == all ones, XOR of bits)
//   out_pop              number of 1 bits in out_y
module ae_pipe #(
    parameter int WIDTH = 32,
    parameter int PW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_f,
    input  logic             in_acc,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_par,
    output logic [PW-1:0]    out_pop
);
    import ae_pkg::*;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] y_comb;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] s1_y_reg;
    logic [WIDTH-1:0] s2_y_reg;
    logic             s1_v_reg;
    logic             s2_v_reg;
    logic             s1_load;
    logic             s2_load;
    logic             accept;

    logic             f_zero;
    logic             f_ones;
    logic             f_par;
    logic [PW-1:0]    f_pop;
    logic             zero_reg;
    logic             ones_reg;
    logic             par_reg;
    logic [PW-1:0]    pop_reg;

    assign op_a = in_acc ? acc_reg : in_a;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign y_comb[gi] = ae_bit(in_f, op_a[gi], in_b[gi]);
    end

    // Each stage advances when it is empty or its downstream neighbour moves;
    // in_ready is therefore combinationally dependent on out_ready.
    assign s2_load  = !s2_v_reg || out_ready;
    assign s1_load  = !s1_v_reg || s2_load;
    assign in_ready = s1_load;
    assign accept   = in_valid && s1_load;

    // Accumulator follows every accepted result so the very next beat can use it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (accept) begin
            acc_reg <= y_comb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_reg <= 1'b0;
            s1_y_reg <= '0;
        end else if (s1_load) begin
            s1_v_reg <= accept;
            if (accept) begin
                s1_y_reg <= y_comb;
            end
        end
    end

    ae_flags #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) u_flags (
        .vec   (s1_y_reg),
        .zero  (f_zero),
        .ones  (f_ones),
        .par   (f_par),
        .pop   (f_pop)
    );

    // Result data only moves when S1 holds a beat, so out_* never show a
    // stale S1 value after the pipe drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_reg <= 1'b0;
            s2_y_reg <= '0;
            zero_reg <= 1'b1;
            ones_reg <= 1'b0;
            par_reg  <= 1'b0;
            pop_reg  <= '0;
        end else if (s2_load) begin
            s2_v_reg <= s1_v_reg;
            if (s1_v_reg) begin
                s2_y_reg <= s1_y_reg;
                zero_reg <= f_zero;
                ones_reg <= f_ones;
                par_reg  <= f_par;
                pop_reg  <= f_pop;
            end
        end
    end

    assign out_valid = s2_v_reg;
    assign out_y     = s2_y_reg;
    assign out_zero  = zero_reg;
    assign out_ones  = ones_reg;
    assign out_par   = par_reg;
    assign out_pop   = pop_reg;

endmodule

// File: doc/ae_pipe.md
# ae_pipe

Pipelined, parametrised bitwise logic unit: applies any of the 16 two-input Boolean functions, selected by a 4-bit truth-table code, across a WIDTH-bit operand pair. It adds valid/ready flow control, a result accumulator for chained operations, and registered result flags (zero, all-ones, parity, popcount). It sits in the ALU datapath as the logic-op execution lane and replaces the purely combinational bitwise unit.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (≥ 2)
- PW, $clog2(WIDTH+1), popcount width (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat offered
- in_ready  out  1  unit accepts beat this cycle
- in_f  in  4  truth-table function code
- in_acc  in  1  1 = use accumulator as operand A, ignore in_a
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- out_valid  out  1  result beat available
- out_ready  in  1  consumer takes result this cycle
- out_y  out  WIDTH  result
- out_zero  out  1  out_y == 0
- out_ones  out  1  out_y == all ones
- out_par  out  1  XOR of all out_y bits
- out_pop  out  PW  number of 1 bits in out_y

## Operation
- Per bit i: y[i] = in_f[{a[i], b[i]}]. So F[0] is a=0,b=0, F[1] is a=0,b=1, F[2] is a=1,b=0, F[3] is a=1,b=1. Examples: AND=1000, OR=1110, XOR=0110, NOR=0001, NOT A=0011, PASS B=1010, ZERO=0000, ONES=1111.
- Operand A = in_acc ? acc : in_a.
- acc: WIDTH-bit register. It is loaded with y on every accepted beat, regardless of in_acc. Because the load happens at the accept edge, back-to-back in_acc beats chain with no bubble.
- Stage 1 (S1): registers y and valid s1_v.
- Stage 2 (S2): registers y, computes the flags from the S1 register and registers them, and registers valid s2_v. out_* are driven directly from the S2 registers.
- Advance rules:
  - S2 loads when !s2_v || out_ready.
  - S1 loads when (!s1_v || S2 loads).
  - in_ready = !s1_v || !s2_v || out_ready. This is a combinational path from out_ready to in_ready, and it is permitted.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- No beat is dropped, duplicated or reordered.

## Timing
- Reset (async assert, sync release): s1_v=0, s2_v=0, acc=0. out_valid=0, out_y=0, out_zero=1, out_ones=0, out_par=0, out_pop=0, in_ready=1.
- Latency: a beat accepted at edge k has out_valid=1 and its result on out_* after edge k+1.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: while out_valid && !out_ready, all out_* stay stable. The pipeline holds at most 2 beats, and in_ready=0 once both stages are full.
- Simultaneous drain and accept with both stages full: S2 takes S1 and S1 takes the new beat in the same edge.
- Empty pipeline: an input with in_valid=0 changes no state, including acc.
- Reset mid-operation: in-flight beats are discarded, acc clears, and no out_valid pulse follows reset release.
- in_acc=1 on the first beat after reset uses acc=0.

## Structure
- Package ae_pkg holds the localparam function codes (AE_F_AND, AE_F_OR, AE_F_XOR, AE_F_NOR, AE_F_NOTA, AE_F_PASSB, AE_F_ZERO, AE_F_ONES). Bench and decoder share it.
- Sub-module ae_flags (parameter WIDTH) is purely combinational: WIDTH-bit vector in; zero, ones, par and pop out. It is instantiated between S1 and S2.
- The bit-function, accumulator and handshake logic live in ae_pipe.

## Test plan
- AND: in_f=1000, A=F0F0_F0F0, B=FF00_FF00, out_ready=1 → two edges later out_y=F000_F000, zero=0, ones=0, par=0, pop=8.
- Accumulator chain, XOR (0110):
  - Beat 1: A=0000_00FF, B=0000_0F0F, in_acc=0 → 0000_0FF0.
  - Beat 2 (next cycle): in_acc=1, B=0000_0FF0 → 0000_0000, zero=1.
- Function sweep: all 16 in_f codes with A=0000_FFFF, B=00FF_00FF. For example ONES (1111) → FFFF_FFFF, ones=1, pop=32, par=0.
- Backpressure: offer 3 beats with out_ready=0 for 5 cycles → 2 beats accepted, in_ready=0, out_* stable. Then raise out_ready → 3 results in order on consecutive cycles.
- Reset: assert rst_n=0 while 2 beats are in flight → out_valid=0 immediately. After release, the first beat with in_acc=1, in_f=1110, B=0000_0001 → 0000_0001.
- WIDTH=8 instance: AND of FF and A5 → A5, pop=4 (PW=4), par=0.
